// File: rtl/dot_row_sequencer.sv
// dot_row_sequencer: start/done scheduler for one row x vector dot-product job
// through the lane-parallel multiply / adder-tree / accumulator datapath.
module dot_row_sequencer #(
    parameter int LANES    = 32,
    parameter int VEC_LEN  = 512,
    parameter int ROWS     = 32,
    parameter int A_W      = 14,
    parameter int B_W      = 9,
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 10,
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ROW_W-1:0] row_idx,
    input  logic             abort,
    output logic [A_W-1:0]   addr_a_base,
    output logic [B_W-1:0]   addr_b_base,
    output logic             issue_valid,
    output logic             c_rd_en,
    output logic [ROW_W-1:0] c_addr,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int BEATS  = VEC_LEN / LANES;
    localparam int BEAT_W = $clog2(BEATS + 1);
    localparam int DRN_W  = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {IDLE, LOAD_C, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [DRN_W-1:0]  drain_q;
    logic [PIPE_LAT-1:0] vpipe_q;
    logic [A_W-1:0]    addr_a_q;
    logic [B_W-1:0]    addr_b_q;
    logic [ROW_W-1:0]  c_addr_q;
    logic [CNT_W-1:0]  cycle_count_q;
    logic              issue_valid_q, c_rd_en_q, acc_clr_q, busy_q, done_q;
    logic [A_W-1:0]    row_base_d;

    assign row_base_d = A_W'(32'(c_addr_q) * 32'(VEC_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            drain_q       <= '0;
            vpipe_q       <= '0;
            addr_a_q      <= '0;
            addr_b_q      <= '0;
            c_addr_q      <= '0;
            cycle_count_q <= '0;
            issue_valid_q <= 1'b0;
            c_rd_en_q     <= 1'b0;
            acc_clr_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            vpipe_q[0] <= issue_valid_q;
            for (int unsigned i = 1; i < PIPE_LAT; i++) vpipe_q[i] <= vpipe_q[i-1];
            if (busy_q && cycle_count_q != '1) cycle_count_q <= cycle_count_q + 1'b1;
            c_rd_en_q <= 1'b0;
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;

            // abort also swallows a same-cycle start while idle
            if (abort) begin
                state_q       <= IDLE;
                vpipe_q       <= '0;
                issue_valid_q <= 1'b0;
                busy_q        <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        c_addr_q      <= row_idx;
                        cycle_count_q <= '0;
                        busy_q        <= 1'b1;
                        c_rd_en_q     <= 1'b1;
                        acc_clr_q     <= 1'b1;
                        state_q       <= LOAD_C;
                    end
                    LOAD_C: begin
                        issue_valid_q <= 1'b1;
                        beat_q        <= '0;
                        addr_a_q      <= row_base_d;
                        addr_b_q      <= '0;
                        state_q       <= ISSUE;
                    end
                    ISSUE: begin
                        if (beat_q == BEAT_W'(BEATS - 1)) begin
                            issue_valid_q <= 1'b0;
                            drain_q       <= '0;
                            state_q       <= DRAIN;
                        end else begin
                            beat_q   <= beat_q + 1'b1;
                            addr_a_q <= addr_a_q + A_W'(LANES);
                            addr_b_q <= addr_b_q + B_W'(LANES);
                        end
                    end
                    DRAIN: begin
                        if (drain_q == DRN_W'(PIPE_LAT - 1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign addr_a_base = addr_a_q;
    assign addr_b_base = addr_b_q;
    assign issue_valid = issue_valid_q;
    assign c_rd_en     = c_rd_en_q;
    assign c_addr      = c_addr_q;
    assign acc_clr     = acc_clr_q;
    assign acc_en      = vpipe_q[PIPE_LAT-1];
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = cycle_count_q;

endmodule
